stump_timer: RTL
================

STUMP_TIMER -- requirements
Module: stump_timer

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port address, input, 16 bits: Stump memory bus address.
REQ-004 SHALL have port wr_data, input, 16 bits: write data, driven from the processor's data_out.
REQ-005 SHALL have port mem_wen, input, 1 bit: memory write enable.
REQ-006 SHALL have port mem_ren, input, 1 bit: memory read enable.
REQ-007 SHALL have port rd_data, output, 16 bits: read data, fed to the processor's data_in.
REQ-008 SHALL have port sel, output, 1 bit: address hits the timer window, for the system data_in mux.
REQ-009 SHALL have port irq, output, 1 bit: timer interrupt request.
REQ-010 SHALL have parameter BASE, default 16'hFF00, meaning: base of the 4-word register window.

Function
REQ-011 SHALL assert sel combinationally iff address[15:2] == BASE[15:2].
REQ-012 SHALL decode four registers in the window: CTRL at +0, PERIOD at +1, COUNT at +2, STATUS at +3.
REQ-013 CTRL SHALL contain these fields:
- bit0 EN;
- bit1 RELOAD;
- bit2 IRQEN;
- bits15:8 PRE (prescale);
- other bits read 0.
REQ-014 SHALL drive rd_data combinationally with the selected register when sel & mem_ren & !mem_wen, else 16'h0000 (zero read latency, matching the single-cycle Stump memory state).
REQ-015 SHALL perform a register write on the clock edge where sel & mem_wen; no write occurs otherwise.
REQ-016 SHALL implement a two-state FSM:
- IDLE: EN=0;
- RUN: EN=1;
- the state is visible as CTRL.EN.
REQ-017 SHALL make a CTRL write with EN=1 take these actions:
- enter RUN;
- clear the prescaler.
A CTRL write with EN=0 SHALL enter IDLE; COUNT SHALL hold in IDLE.
REQ-018 SHALL run the prescaler only in RUN; it counts 0..PRE and emits a one-cycle tick when it equals PRE, then wraps to 0. Tick period SHALL be PRE+1 clocks (PRE=0 gives a tick every clock).
REQ-019 On a tick with COUNT != 0, SHALL decrement COUNT by 1.
REQ-020 On a tick with COUNT == 0 (expiry), SHALL take these actions:
- set STATUS[0];
- if RELOAD=1: load COUNT <= PERIOD and stay in RUN;
- else: clear EN and go to IDLE with COUNT held at 0.
REQ-021 SHALL let a COUNT write overwrite COUNT and take priority over a same-cycle decrement or reload.
REQ-022 SHALL let a CTRL write take priority over a same-cycle expiry clearing EN.
REQ-023 SHALL clear STATUS[0] on a STATUS write with wr_data[0]=1 (write-1-to-clear); a same-cycle expiry SHALL win, leaving the bit set.
REQ-024 SHALL take effect on the next tick for a PERIOD write; PERIOD=0 with RELOAD SHALL expire on every tick.
REQ-025 SHALL drive irq = STATUS[0] & IRQEN, registered-level (no extra latency beyond STATUS).
REQ-026 Decrement SHALL be modulo 2^16 without underflow past 0 (expiry handles 0).

Reset
REQ-027 On rst, SHALL clear these to 0:
- CTRL;
- PERIOD;
- COUNT;
- STATUS;
- prescaler;
- FSM (IDLE).
Outputs SHALL then be irq=0, rd_data=0.
REQ-028 SHALL let rst override a same-cycle bus write; rst mid-count SHALL abort the count with no expiry.

Structure
REQ-029 SHALL place register offsets, CTRL bit positions, the default BASE and the FSM state encodings in the shared Stump definitions include.
REQ-030 SHALL implement the prescaler as sub-module stump_timer_prescaler (inputs clk, rst, run, clear, pre[7:0]; output tick).
REQ-031 SHALL stay within 120-400 lines of RTL in total.

Verification
REQ-032 Reset check: assert rst, then read all 4 registers -> 16'h0000 each; irq=0.
REQ-033 One-shot expiry:
- stimulus: write PERIOD=3, COUNT=3, then CTRL=16'h0005 (EN, IRQEN, PRE=0);
- STATUS[0] and irq SHALL be set exactly 4 clocks after the CTRL write edge;
- EN SHALL then read 0 and COUNT SHALL read 0.
REQ-034 Prescale with reload:
- stimulus: write CTRL with PRE=2, RELOAD=1, EN=1 and COUNT=1, PERIOD=1;
- expiries SHALL occur every 6 clocks;
- COUNT SHALL alternate 1, 0.
REQ-035 Clear versus set race:
- stimulus: write STATUS=1 on the same edge as an expiry;
- STATUS[0] SHALL remain 1;
- a W1C on a later non-expiry edge SHALL clear it.
REQ-036 COUNT write race: writing COUNT=16'h0010 on a tick edge -> COUNT reads 16'h0010, not the decremented value.
REQ-037 Decode and reset abort:
- address 16'hFF04 with mem_ren SHALL give sel=0 and rd_data=0;
- rst asserted mid-count SHALL give all registers 0 and no irq afterwards.

Source files
------------

// File: rtl/stump_timer_pkg.sv
// stump_timer_pkg -- shared definitions for the Stump memory-mapped timer.
//   Register word offsets within the 4-word window, CTRL bit positions,
//   the default window base and the two-state timer FSM encoding.
package stump_timer_pkg;

    // Default base of the 4-word register window.
    localparam logic [15:0] STUMP_TIMER_BASE = 16'hFF00;

    // Register offsets (address[1:0]).
    localparam logic [1:0] OFS_CTRL   = 2'd0;
    localparam logic [1:0] OFS_PERIOD = 2'd1;
    localparam logic [1:0] OFS_COUNT  = 2'd2;
    localparam logic [1:0] OFS_STATUS = 2'd3;

    // CTRL bit positions; PRE occupies CTRL[15:8].
    localparam int CTRL_EN      = 0;
    localparam int CTRL_RELOAD  = 1;
    localparam int CTRL_IRQEN   = 2;
    localparam int CTRL_PRE_LSB = 8;

    // Timer FSM; the state is what CTRL.EN reads back.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/stump_timer_prescaler.sv
// stump_timer_prescaler -- divides the clock by pre+1 while the timer runs.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   run   : count only while high; the counter is held at 0 otherwise
//   clear : restart the count from 0 on this edge
//   pre   : prescale value; tick period is pre+1 clocks
//   tick  : one-cycle pulse in the cycle the counter equals pre
module stump_timer_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clear,
    input  logic [7:0] pre,
    output logic       tick
);

    logic [7:0] cnt;

    // tick is decoded from the counter register, so it is glitch-free and
    // lines up with the edge on which the counter wraps.
    assign tick = run && (cnt == pre);

    always_ff @(posedge clk) begin
        if (rst || clear || !run) begin
            cnt <= 8'd0;
        end else if (cnt == pre) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/stump_timer.sv
// stump_timer -- memory-mapped down-counting timer for the Stump bus.
//   Window of four words at BASE: CTRL (+0), PERIOD (+1), COUNT (+2),
//   STATUS (+3). CTRL = {PRE[7:0], 5'b0, IRQEN, RELOAD, EN}.
//   clk, rst         : clock, synchronous active-high reset
//   address          : bus address
//   wr_data          : write data (processor data_out)
//   mem_wen, mem_ren : bus write / read enables
//   rd_data          : combinational read data (processor data_in)
//   sel              : address lies inside the timer window
//   irq              : STATUS[0] & IRQEN
module stump_timer
    import stump_timer_pkg::*;
#(
    parameter logic [15:0] BASE = STUMP_TIMER_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [15:0] wr_data,
    input  logic        mem_wen,
    input  logic        mem_ren,
    output logic [15:0] rd_data,
    output logic        sel,
    output logic        irq
);

    timer_state_t state;
    logic         reload;
    logic         irqen;
    logic [7:0]   pre;
    logic [15:0]  period;
    logic [15:0]  count;
    logic         status;

    logic reg_wr, wr_ctrl, wr_period, wr_count, wr_status;
    logic tick, expiry;

    assign sel       = (address[15:2] == BASE[15:2]);
    assign reg_wr    = sel && mem_wen;
    assign wr_ctrl   = reg_wr && (address[1:0] == OFS_CTRL);
    assign wr_period = reg_wr && (address[1:0] == OFS_PERIOD);
    assign wr_count  = reg_wr && (address[1:0] == OFS_COUNT);
    assign wr_status = reg_wr && (address[1:0] == OFS_STATUS);

    // Any CTRL write restarts the prescale phase.
    stump_timer_prescaler u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (state == ST_RUN),
        .clear (wr_ctrl),
        .pre   (pre),
        .tick  (tick)
    );

    assign expiry = tick && (count == 16'd0);
    assign irq    = status && irqen;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            reload <= 1'b0;
            irqen  <= 1'b0;
            pre    <= 8'd0;
            period <= 16'd0;
            count  <= 16'd0;
            status <= 1'b0;
        end else begin
            // FSM: a CTRL write beats an expiry that would clear EN.
            if (wr_ctrl) begin
                state  <= wr_data[CTRL_EN] ? ST_RUN : ST_IDLE;
                reload <= wr_data[CTRL_RELOAD];
                irqen  <= wr_data[CTRL_IRQEN];
                pre    <= wr_data[CTRL_PRE_LSB +: 8];
            end else if (expiry && !reload) begin
                state <= ST_IDLE;
            end

            if (wr_period) begin
                period <= wr_data;
            end

            // A bus write to COUNT beats decrement and reload. At zero
            // without RELOAD the count simply stays at 0.
            if (wr_count) begin
                count <= wr_data;
            end else if (tick) begin
                if (count != 16'd0) begin
                    count <= count - 16'd1;
                end else if (reload) begin
                    count <= period;
                end
            end

            // Write-1-to-clear; an expiry on the same edge wins.
            status <= (status && !(wr_status && wr_data[0])) || expiry;
        end
    end

    always_comb begin
        rd_data = 16'h0000;
        if (sel && mem_ren && !mem_wen) begin
            case (address[1:0])
                OFS_CTRL:   rd_data = {pre, 5'b0, irqen, reload, (state == ST_RUN)};
                OFS_PERIOD: rd_data = period;
                OFS_COUNT:  rd_data = count;
                default:    rd_data = {15'b0, status};
            endcase
        end
    end

endmodule
